// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: the opcodes whose results are
// never shown on the display, and the hex-to-segment table (bit 6 = a, bit 0 = g).
package seven_seg_pkg;

    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef enum logic {
        LOAD_ACCEPT = 1'b0,
        LOAD_DROP   = 1'b1
    } load_class_e;

    // Jumps and upper-immediate forms produce addresses, not data worth displaying.
    function automatic load_class_e classify(input logic [6:0] op);
        if ((op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC))
            return LOAD_DROP;
        return LOAD_ACCEPT;
    endfunction

endpackage

// File: rtl/seven_seg_enc.sv
// Combinational hex nibble to seven-segment decoder (active-high segments).
module seven_seg_enc
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex display driver with registered seg/an outputs.
// Define SEVEN_SEG_LZB_EN to blank leading zero digits (digit 0 always shown).
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_CNT    = 50000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      load,
    input  logic [6:0]                opcode,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done,
    output logic                      load_ack
);

    localparam int CW = $clog2(DIV_CNT);
    localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] AN_FIRST = NUM_DIGITS'(1);
    localparam logic [6:0]            SEG_POL  = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_POL   = {NUM_DIGITS{ACTIVE_LOW}};

    logic [4*NUM_DIGITS-1:0] disp;
    logic [CW-1:0]           slot_cnt;
    logic [PW-1:0]           ptr;
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    ack_q;

    logic                    load_ok;
    logic                    slot_end;
    logic                    ptr_last;
    logic [3:0]              nib;
    logic                    blank;
    logic [6:0]              enc_seg;
    logic [6:0]              seg_pre;
    logic [NUM_DIGITS-1:0]   an_pre;

    assign load_ok  = load && (classify(opcode) == LOAD_ACCEPT);
    assign slot_end = (slot_cnt == CW'(DIV_CNT - 1));
    assign ptr_last = (ptr == PW'(NUM_DIGITS - 1));

    always_comb begin
        nib    = 4'h0;
        blank  = 1'b0;
        an_pre = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (ptr == PW'(k)) begin
                nib       = disp[4*k +: 4];
                an_pre[k] = 1'b1;
`ifdef SEVEN_SEG_LZB_EN
                // A digit is leading when it and everything above it are zero.
                if (k != 0)
                    blank = ((disp >> (4*k)) == '0);
`endif
            end
        end
    end

    seven_seg_enc u_enc (
        .nibble (nib),
        .seg    (enc_seg)
    );

    assign seg_pre = blank ? SEG_BLANK : enc_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            disp     <= '0;
            slot_cnt <= '0;
            ptr      <= '0;
            ack_q    <= 1'b0;
            seg_q    <= SEG_TABLE[0] ^ SEG_POL;
            an_q     <= AN_FIRST ^ AN_POL;
        end else begin
            ack_q <= load_ok;
            if (load_ok)
                disp <= value;
            seg_q <= seg_pre ^ SEG_POL;
            an_q  <= an_pre ^ AN_POL;
            if (slot_end) begin
                slot_cnt <= '0;
                ptr      <= ptr_last ? '0 : ptr + PW'(1);
            end else begin
                slot_cnt <= slot_cnt + CW'(1);
            end
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign load_ack   = ack_q;
    assign frame_done = slot_end && ptr_last;

endmodule
